// File: rtl/simon_pkg.sv
// Shared types and constants for the lamp/tone player: code type, FSM states, tone half-periods.
package simon_pkg;

  typedef logic [1:0] lamp_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } lamp_state_e;

  localparam int unsigned TONE_W = 5;

  // Tone half-period in clock cycles for each lamp code.
  function automatic logic [TONE_W-1:0] tone_half(input lamp_code_t code);
    logic [TONE_W-1:0] h;
    case (code)
      2'd0:    h = 5'd24;
      2'd1:    h = 5'd20;
      2'd2:    h = 5'd16;
      default: h = 5'd12;
    endcase
    return h;
  endfunction

  function automatic logic [3:0] lamp_onehot(input lamp_code_t code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/lamp_fifo.sv
// Synchronous code FIFO with flush; push is rejected when full, pop ignored when empty.
module lamp_fifo
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  lamp_code_t data_i,
  input  logic       pop_i,
  output lamp_code_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  lamp_code_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      // Pointers are power-of-two wide, so increment wraps modulo DEPTH.
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/lamp_player.sv
// Plays buffered lamp codes: lamp plus code-pitched tone for ON_TICKS, dark for GAP_TICKS, one IDLE cycle.
module lamp_player
  import simon_pkg::*;
#(
  parameter int unsigned ON_TICKS   = 3000,
  parameter int unsigned GAP_TICKS  = 1000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] CODE,
  input  logic       CODE_VALID,
  output logic       CODE_READY,
  input  logic       FLUSH,
  output logic [3:0] LAMP,
  output logic       TONE,
  output logic       BUSY
);

  localparam int unsigned MAX_T = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int unsigned DUR_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam logic [DUR_W-1:0] ON_LAST  = DUR_W'(ON_TICKS - 1);
  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);

  lamp_state_e       state_q, state_d;
  lamp_code_t        code_q, code_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [TONE_W-1:0] tcnt_q, tcnt_d;
  logic              tone_q, tone_d;

  lamp_code_t        fifo_head;
  logic              fifo_full, fifo_empty;
  logic              pop;

  lamp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .flush_i (FLUSH),
    .push_i  (CODE_VALID),
    .data_i  (CODE),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign CODE_READY = !fifo_full;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (FLUSH) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_d = ST_ON;
            pop     = 1'b1;
          end
        end
        ST_ON:   if (dur_q == ON_LAST)  state_d = ST_GAP;
        ST_GAP:  if (dur_q == GAP_LAST) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    code_d = pop ? fifo_head : code_q;

    // Duration restarts on every phase change and only runs inside ON/GAP.
    if (state_d != state_q || state_q == ST_IDLE) begin
      dur_d = '0;
    end else begin
      dur_d = dur_q + 1'b1;
    end

    if (state_q == ST_ON && state_d == ST_ON) begin
      if (tcnt_q == tone_half(code_q) - 1'b1) begin
        tcnt_d = '0;
        tone_d = !tone_q;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
        tone_d = tone_q;
      end
    end else begin
      tcnt_d = '0;
      tone_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      code_q <= '0;
      dur_q  <= '0;
      tcnt_q <= '0;
      tone_q <= 1'b0;
    end else begin
      code_q <= code_d;
      dur_q  <= dur_d;
      tcnt_q <= tcnt_d;
      tone_q <= tone_d;
    end
  end

  always_comb begin
    LAMP = '0;
    TONE = 1'b0;
    if (state_q == ST_ON) begin
      LAMP = lamp_onehot(code_q);
      TONE = tone_q;
    end
    BUSY = (state_q != ST_IDLE) || !fifo_empty;
  end

endmodule

// File: tb/tb_lamp_player.sv
// Self-checking bench for lamp_player against a queue/timeline reference model.
module tb_lamp_player;

  localparam int ON   = 4;
  localparam int GAP  = 2;
  localparam int DEP  = 4;
  localparam int T_ON = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] code = '0;
  logic       valid = 1'b0;
  logic       flush = 1'b0;
  logic       ready, tone, busy;
  logic [3:0] lamp;

  logic [1:0] t_code = '0;
  logic       t_valid = 1'b0;
  logic       t_ready, t_tone, t_busy;
  logic [3:0] t_lamp;

  int errors = 0;
  int checks = 0;

  // Reference model: queued codes plus the playing code and cycles since its start.
  int q[$];
  bit act = 1'b0;
  int t = 0;
  int pcode = 0;
  int half_tab[4] = '{24, 20, 16, 12};

  always #5 clk = ~clk;

  lamp_player #(.ON_TICKS(ON), .GAP_TICKS(GAP), .FIFO_DEPTH(DEP)) dut (
    .CLK(clk), .RST_N(rst_n), .CODE(code), .CODE_VALID(valid), .CODE_READY(ready),
    .FLUSH(flush), .LAMP(lamp), .TONE(tone), .BUSY(busy)
  );

  lamp_player #(.ON_TICKS(T_ON), .GAP_TICKS(GAP), .FIFO_DEPTH(DEP)) dut_t (
    .CLK(clk), .RST_N(rst_n), .CODE(t_code), .CODE_VALID(t_valid), .CODE_READY(t_ready),
    .FLUSH(1'b0), .LAMP(t_lamp), .TONE(t_tone), .BUSY(t_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return q.size() < DEP;
  endfunction

  task automatic model_step(input bit v, input int c, input bit f);
    int pre;
    if (f) begin
      q.delete();
      act = 1'b0;
      return;
    end
    pre = q.size();
    if (!act || t == ON + GAP) begin
      if (pre > 0) begin
        pcode = q.pop_front();
        act = 1'b1;
        t = 0;
      end else begin
        act = 1'b0;
      end
    end else begin
      t++;
    end
    if (v && pre < DEP) q.push_back(c);
  endtask

  task automatic check_model(input string tag);
    int e_lamp, e_tone, e_busy;
    e_lamp = (act && t < ON) ? (1 << pcode) : 0;
    e_tone = (act && t < ON) ? ((t / half_tab[pcode]) % 2) : 0;
    e_busy = ((act && t < ON + GAP) || q.size() > 0) ? 1 : 0;
    chk({tag, ".lamp"}, 32'(lamp), 32'(e_lamp));
    chk({tag, ".tone"}, 32'(tone), 32'(e_tone));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".ready"}, 32'(ready), 32'(m_ready()));
  endtask

  task automatic cyc(input string tag, input bit v, input int c, input bit f);
    valid = v;
    code  = 2'(c);
    flush = f;
    @(posedge clk);
    model_step(v, c, f);
    #1;
    check_model(tag);
  endtask

  initial begin
    int seq[5];
    int idx;
    bit acc;
    int k;

    // Reset state
    #12;
    chk("rst.lamp", 32'(lamp), 32'h0);
    chk("rst.tone", 32'(tone), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.ready", 32'(ready), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("idle", 0, 0, 0);

    // Single push of code 2: lamp on E1..E4, dark E5..E6, idle E7
    cyc("single.e0", 1, 2, 0);
    for (int i = 1; i <= 7; i++) begin
      cyc("single", 0, 0, 0);
      if (i >= 1 && i <= 4) chk("single.on", 32'(lamp), 32'h4);
      if (i == 7) chk("single.busyfall", 32'(busy), 32'h0);
    end

    // Back-to-back 0,1,2,3,0 with VALID held
    seq = '{0, 1, 2, 3, 0};
    idx = 0;
    for (int i = 0; i < 40 && idx < 5; i++) begin
      acc = m_ready();
      cyc("b2b", 1, seq[idx], 0);
      if (acc) idx++;
    end
    chk("b2b.accepted", 32'(idx), 32'd5);
    for (int i = 0; i < 40; i++) cyc("b2b.drain", 0, 0, 0);

    // FLUSH during ON with codes queued; push in same cycle dropped
    cyc("fl.p0", 1, 0, 0);
    cyc("fl.p1", 1, 1, 0);
    cyc("fl.p2", 1, 2, 0);
    cyc("fl.p3", 1, 3, 0);
    cyc("fl.flush", 1, 3, 1);
    chk("fl.lamp0", 32'(lamp), 32'h0);
    chk("fl.busy0", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) cyc("fl.after", 0, 0, 0);
    cyc("fl.push1", 1, 1, 0);
    cyc("fl.play", 0, 0, 0);
    chk("fl.lamp1", 32'(lamp), 32'h2);
    for (int i = 0; i < 10; i++) cyc("fl.drain", 0, 0, 0);

    // Reset mid-GAP with another code queued
    cyc("rg.p0", 1, 1, 0);
    cyc("rg.p1", 1, 3, 0);
    for (int i = 0; i < ON + 1; i++) cyc("rg.run", 0, 0, 0);
    rst_n = 1'b0;
    valid = 1'b1;
    code  = 2'd2;
    #1;
    chk("rg.lamp", 32'(lamp), 32'h0);
    chk("rg.tone", 32'(tone), 32'h0);
    chk("rg.busy", 32'(busy), 32'h0);
    chk("rg.ready", 32'(ready), 32'h1);
    q.delete();
    act = 1'b0;
    @(posedge clk); #1;
    chk("rg.held", 32'(busy), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc("rg.after", 0, 0, 0);

    // Simultaneous push and pop at count 2
    cyc("pp.a", 1, 3, 0);
    cyc("pp.b", 1, 2, 0);
    cyc("pp.c", 1, 1, 0);
    k = 0;
    while (!(act && t == ON + GAP) && k < 20) begin
      cyc("pp.wait", 0, 0, 0);
      k++;
    end
    chk("pp.reached", 32'(k < 20), 32'h1);
    cyc("pp.d", 1, 0, 0);
    for (int i = 0; i < 30; i++) cyc("pp.drain", 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 40; i++) cyc("rnd.drain", 0, 0, 0);

    // Tone of code 3 with a 60-cycle ON phase
    t_valid = 1'b1;
    t_code  = 2'd3;
    @(posedge clk); #1;
    t_valid = 1'b0;
    @(posedge clk); #1;
    chk("tone.lamp", 32'(t_lamp), 32'h8);
    for (int j = 0; j < T_ON; j++) begin
      chk("tone.on", 32'(t_tone), 32'((j / 12) % 2));
      @(posedge clk); #1;
    end
    for (int j = 0; j < GAP; j++) begin
      chk("tone.gap", 32'(t_tone), 32'h0);
      chk("tone.gaplamp", 32'(t_lamp), 32'h0);
      @(posedge clk); #1;
    end
    chk("tone.idle", 32'(t_busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
